// File: rtl/count_seq_pkg.sv
// Shared encodings for the count sequencer: command ops, FSM states and run modes.
// Pure constants; no timing or flow-control behaviour lives here.
package count_seq_pkg;

  localparam logic [1:0] OP_START_ONESHOT  = 2'd0;
  localparam logic [1:0] OP_START_PERIODIC = 2'd1;
  localparam logic [1:0] OP_STOP           = 2'd2;
  localparam logic [1:0] OP_CLEAR          = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up-counter register; clear has priority over increment, one-cycle update.
// No flow control: the sequencer decides every cycle whether to clear or increment.
module count_core #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= o_count + WIDTH'(1'b1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven FSM around count_core: one-shot or periodic counting to a latched limit.
// Commands take effect on the accepting edge; ready is always high out of reset, pulses are registered.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_limit,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic [1:0]       o_state
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic             accept;
  logic             is_start;
  logic             core_clr;
  logic             core_inc;
  logic             done_next;
  logic             wrap_next;

  count_core #(.WIDTH(WIDTH)) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (core_clr),
    .i_inc   (core_inc),
    .o_count (o_count)
  );

  assign accept   = i_cmd_valid & o_cmd_ready;
  assign is_start = (i_cmd_op == OP_START_ONESHOT) || (i_cmd_op == OP_START_PERIODIC);

  // An accepted command always overrides the terminal-count action on the same edge.
  always_comb begin
    state_next = state;
    core_clr   = 1'b0;
    core_inc   = 1'b0;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    if (accept) begin
      case (i_cmd_op)
        OP_START_ONESHOT,
        OP_START_PERIODIC: begin
          core_clr   = 1'b1;
          state_next = ST_RUN;
        end
        OP_STOP: begin
          state_next = ST_IDLE;
        end
        default: begin
          core_clr   = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end else if (state == ST_RUN && i_en) begin
      if (o_count != limit) begin
        core_inc = 1'b1;
      end else if (mode == MODE_ONESHOT) begin
        state_next = ST_HOLD;
        done_next  = 1'b1;
      end else begin
        core_clr  = 1'b1;
        wrap_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      limit       <= '0;
      mode        <= MODE_ONESHOT;
      o_done      <= 1'b0;
      o_wrap      <= 1'b0;
      o_cmd_ready <= 1'b0;
    end else begin
      state       <= state_next;
      o_done      <= done_next;
      o_wrap      <= wrap_next;
      o_cmd_ready <= 1'b1;
      if (accept && is_start) begin
        limit <= i_cmd_limit;
        mode  <= (i_cmd_op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
      end
    end
  end

  assign o_busy  = (state == ST_RUN);
  assign o_state = state;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus pushes expected post-edge snapshots,
// a monitor pops and compares them at the falling edge (or on a mid-cycle probe).
module tb_count_sequencer;

  localparam logic [1:0] C_OS   = 2'd0;
  localparam logic [1:0] C_PER  = 2'd1;
  localparam logic [1:0] C_STOP = 2'd2;
  localparam logic [1:0] C_CLR  = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef struct {
    string       nm;
    logic [13:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_limit = 8'd0;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [1:0] state;
  logic       probe = 1'b0;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  count_sequencer #(.WIDTH(8)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_en        (en),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_limit (cmd_limit),
    .o_count     (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_wrap      (wrap),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [7:0] ec, input logic [1:0] es,
                      input logic ed, input logic ew, input logic er);
    exp_t e;
    e.nm = nm;
    e.v  = {ec, es, (es == S_RUN), ed, ew, er};
    q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge happen, queue the expected result.
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] lim, input logic e,
                      input string nm, input logic [7:0] ec, input logic [1:0] es,
                      input logic ed, input logic ew);
    cmd_valid = v;
    cmd_op    = op;
    cmd_limit = lim;
    en        = e;
    @(posedge clk);
    push(nm, ec, es, ed, ew, 1'b1);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [13:0] act;
    forever begin
      @(negedge clk or posedge probe);
      while (q.size() != 0) begin
        e   = q.pop_front();
        act = {count, state, busy, done, wrap, cmd_ready};
        vectors++;
        if (act !== e.v) begin
          miscompares++;
          $display("FAIL %s: got cnt=%0d st=%0d busy=%b done=%b wrap=%b rdy=%b, want cnt=%0d st=%0d busy=%b done=%b wrap=%b rdy=%b",
                   e.nm, act[13:6], act[5:4], act[3], act[2], act[1], act[0],
                   e.v[13:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 push("reset", 8'd0, S_IDLE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, C_OS, 8'd0, 1, "post_reset", 8'd0, S_IDLE, 0, 0);

    // One-shot, limit 5
    step(1, C_OS, 8'd5, 1, "os5_start", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_c1", 8'd1, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_c2", 8'd2, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_c3", 8'd3, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_c4", 8'd4, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_c5", 8'd5, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_done", 8'd5, S_HOLD, 1, 0);
    step(0, C_OS, 8'd0, 1, "os5_hold1", 8'd5, S_HOLD, 0, 0);
    step(0, C_OS, 8'd0, 1, "os5_hold2", 8'd5, S_HOLD, 0, 0);

    // Periodic, limit 3, 12 enabled edges: 1,2,3,0(wrap),...
    step(1, C_PER, 8'd3, 1, "per3_start", 8'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, C_OS, 8'd0, 1, $sformatf("per3_e%0d", i), 8'(i % 4), S_RUN, 0, (i % 4) == 0);

    // Periodic, limit 10, enable toggling; 11th enabled edge (step 21) wraps
    step(1, C_PER, 8'd10, 1, "per10_start", 8'd0, S_RUN, 0, 0);
    for (int j = 1; j <= 22; j++) begin
      int ecnt;
      ecnt = (j + 1) / 2;
      step(0, C_OS, 8'd0, (j % 2) == 1, $sformatf("per10_j%0d", j),
           (ecnt == 11) ? 8'd0 : 8'(ecnt), S_RUN, 0, j == 21);
    end

    // limit = 0
    step(1, C_OS, 8'd0, 1, "os0_start", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os0_done", 8'd0, S_HOLD, 1, 0);
    step(0, C_OS, 8'd0, 1, "os0_hold", 8'd0, S_HOLD, 0, 0);
    step(1, C_PER, 8'd0, 1, "per0_start", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "per0_w1", 8'd0, S_RUN, 0, 1);
    step(0, C_OS, 8'd0, 1, "per0_w2", 8'd0, S_RUN, 0, 1);
    step(0, C_OS, 8'd0, 1, "per0_w3", 8'd0, S_RUN, 0, 1);
    step(0, C_OS, 8'd0, 0, "per0_off", 8'd0, S_RUN, 0, 0);

    // STOP at 4, CLEAR, restart with limit 2
    step(1, C_OS, 8'd9, 1, "stop_start", 8'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 4; i++)
      step(0, C_OS, 8'd0, 1, $sformatf("stop_c%0d", i), 8'(i), S_RUN, 0, 0);
    step(1, C_STOP, 8'd0, 1, "stop", 8'd4, S_IDLE, 0, 0);
    step(0, C_OS, 8'd0, 1, "idle_frozen", 8'd4, S_IDLE, 0, 0);
    step(1, C_CLR, 8'd0, 1, "clear", 8'd0, S_IDLE, 0, 0);
    step(1, C_OS, 8'd2, 1, "os2_start", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os2_c1", 8'd1, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os2_c2", 8'd2, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "os2_done", 8'd2, S_HOLD, 1, 0);

    // START lands on the terminal edge of a limit-3 one-shot: command wins
    step(1, C_OS, 8'd3, 1, "term_start", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "term_c1", 8'd1, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "term_c2", 8'd2, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "term_c3", 8'd3, S_RUN, 0, 0);
    step(1, C_OS, 8'd3, 1, "term_restart", 8'd0, S_RUN, 0, 0);
    step(0, C_OS, 8'd0, 1, "term_after", 8'd1, S_RUN, 0, 0);

    // Asynchronous reset mid-run at count 7
    step(1, C_PER, 8'd20, 1, "rst_start", 8'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 7; i++)
      step(0, C_OS, 8'd0, 1, $sformatf("rst_c%0d", i), 8'(i), S_RUN, 0, 0);
    #2 rst = 1'b1;
    #1 push("async_reset", 8'd0, S_IDLE, 1'b0, 1'b0, 1'b0);
    probe = 1'b1;
    #1 probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(0, C_OS, 8'd0, 1, "post_rst_idle", 8'd0, S_IDLE, 0, 0);
    step(0, C_OS, 8'd0, 1, "post_rst_idle2", 8'd0, S_IDLE, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
